jtag_gpios_seq: RTL

- Local sequencer that owns the jtag_gpios scan chain.
- Accepts register-level read/write requests from a system-side master.
- Generates the scan_n_ir / extest_ir / capture_dr / shift_dr / update_dr / tdi sequence.
- Deserialises gpios_tdo into a response word.
- Runs in the tck domain and replaces a TAP when the GPIO block is used without an external JTAG host.

---
 rtl/jtag_gpios_pkg.sv | 22 ++
 rtl/jtag_gpios_seq_if.sv | 32 +++
 rtl/jtag_gpios_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jtag_gpios_pkg.sv
// Shared types and constants for the jtag_gpios scan-chain sequencer.
// State encoding, register-select codes and the shift counter width helper.
package jtag_gpios_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CAP,
        SHIFT,
        UPD,
        RESP
    } state_t;

    localparam logic SEL_CONFIG = 1'b0;
    localparam logic SEL_DATA   = 1'b1;

    // Counter must reach NR_GPIOS (the write-enable bit position).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/jtag_gpios_seq_if.sv
// Request/response handshake plus scan-chain strobes of the sequencer.
// master = system side and chain model, slave = sequencer.
interface jtag_gpios_seq_if #(
    parameter int NR_GPIOS = 1
);
    logic                req_valid;
    logic                req_ready;
    logic                req_sel;
    logic                req_write;
    logic [NR_GPIOS-1:0] req_wdata;
    logic                rsp_valid;
    logic [NR_GPIOS-1:0] rsp_rdata;
    logic                scan_n_ir;
    logic                extest_ir;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic                tdi;
    logic                gpios_tdo;

    modport master (
        output req_valid, req_sel, req_write, req_wdata, gpios_tdo,
        input  req_ready, rsp_valid, rsp_rdata,
        input  scan_n_ir, extest_ir, capture_dr, shift_dr, update_dr, tdi
    );

    modport slave (
        input  req_valid, req_sel, req_write, req_wdata, gpios_tdo,
        output req_ready, rsp_valid, rsp_rdata,
        output scan_n_ir, extest_ir, capture_dr, shift_dr, update_dr, tdi
    );
endinterface

// File: rtl/jtag_gpios_seq.sv
// Local sequencer driving the jtag_gpios chain from register requests.
// Optional macro JTAG_GPIOS_SEQ_SEL_CACHE_EN skips SEL on a repeated select.
module jtag_gpios_seq
    import jtag_gpios_pkg::*;
#(
    parameter int NR_GPIOS = 1
) (
    input  logic             tck,
    input  logic             reset,
    jtag_gpios_seq_if.slave  bus
);

    localparam int            CW   = cnt_width(NR_GPIOS);
    localparam logic [CW-1:0] LAST = CW'(NR_GPIOS);

    state_t              r_state;
    state_t              w_next;
    logic                r_sel;
    logic                r_write;
    logic [NR_GPIOS-1:0] r_wdata;
    logic [NR_GPIOS-1:0] r_shreg;
    logic [NR_GPIOS-1:0] r_rdata;
    logic [CW-1:0]       r_cnt;
    logic                w_accept;
    logic                w_skip_sel;
    logic [NR_GPIOS:0]   w_chain;
    logic [NR_GPIOS-1:0] w_shnext;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_chain  = {r_write, r_wdata};
    assign bus.rsp_rdata = r_rdata;

`ifdef JTAG_GPIOS_SEQ_SEL_CACHE_EN
    logic r_cvalid;
    logic r_csel;

    // Remember the last select shifted into the chain's IR mux
    always_ff @(posedge tck) begin
        if (reset) begin
            r_cvalid <= 1'b0;
            r_csel   <= 1'b0;
        end else if (r_state == SEL) begin
            r_cvalid <= 1'b1;
            r_csel   <= r_sel;
        end
    end

    assign w_skip_sel = r_cvalid && (r_csel == bus.req_sel);
`else
    assign w_skip_sel = 1'b0;
`endif

    // Incoming tdo enters at the MSB so bit k ends up holding sample k
    always_comb begin
        w_shnext = r_shreg >> 1;
        w_shnext[NR_GPIOS-1] = bus.gpios_tdo;
    end

    // State register
    always_ff @(posedge tck) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, bit counter, deserialiser and response word
    always_ff @(posedge tck) begin
        if (reset) begin
            r_sel   <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_sel   <= bus.req_sel;
                r_write <= bus.req_write;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == CAP) begin
                r_cnt <= '0;
            end
            if (r_state == SHIFT) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt != LAST) begin
                    r_shreg <= w_shnext;
                end
            end
            if (r_state == UPD) begin
                r_rdata <= r_shreg;
            end
        end
    end

    // Next state and Moore-decoded strobes
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.scan_n_ir  = 1'b0;
        bus.extest_ir  = 1'b0;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b0;
        bus.tdi        = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = w_skip_sel ? CAP : SEL;
                end
            end
            SEL: begin
                bus.scan_n_ir = 1'b1;
                bus.shift_dr  = 1'b1;
                bus.tdi       = r_sel;
                w_next        = CAP;
            end
            CAP: begin
                bus.extest_ir  = 1'b1;
                bus.capture_dr = 1'b1;
                w_next         = SHIFT;
            end
            SHIFT: begin
                bus.extest_ir = 1'b1;
                bus.shift_dr  = 1'b1;
                bus.tdi       = w_chain[r_cnt];
                if (r_cnt == LAST) begin
                    w_next = UPD;
                end
            end
            UPD: begin
                bus.extest_ir = 1'b1;
                bus.update_dr = 1'b1;
                w_next        = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                w_next        = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
